// File: rtl/gb_cpu_common_pkg.sv
// Shared Game Boy CPU definitions: interrupt bit map, IE address, IRQ vector type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gb_cpu_common_pkg;

  // Interrupt source bit positions inside IE/IF
  localparam int unsigned IRQ_VBLANK = 0;
  localparam int unsigned IRQ_STAT   = 1;
  localparam int unsigned IRQ_TIMER  = 2;
  localparam int unsigned IRQ_SERIAL = 3;
  localparam int unsigned IRQ_JOYPAD = 4;

  // Interrupt-enable register lives at the very top of the address map
  localparam logic [15:0] IE_ADDR = 16'hFFFF;

  // Last valid HRAM address; HRAM never reaches IE_ADDR
  localparam logic [15:0] HRAM_LAST = 16'hFFFE;

  // One bit per interrupt source
  typedef logic [IRQ_JOYPAD:0] irq_vec_t;

  // Which register/storage an address decodes to
  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_HRAM = 2'd1,
    TGT_IE   = 2'd2,
    TGT_IF   = 2'd3
  } tgt_e;

endpackage

// File: rtl/gb_cpu_hram.sv
// 127x8 high RAM: synchronous write, combinational read, not reset.
// Latency: read 0 cycles (combinational), write lands at the rising edge.
// Backpressure: none; accepts one access every cycle.
module gb_cpu_hram (
  input  logic       clk,
  input  logic       we_i,
  input  logic [6:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [0:126];

  // Index 127 has no storage behind it; return open-bus value
  assign rdata_o = (addr_i == 7'd127) ? 8'hFF : mem_q[addr_i];

  // Byte write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we_i && (addr_i != 7'd127)) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/gb_cpu_hram_responder.sv
// Bus responder for HRAM, IE and IF: address decode, interrupt flag logic, registered read port.
// Latency: read data and rdata_valid one cycle after an accepted read; writes land at the edge.
// Backpressure: none; a read or write can be accepted every cycle at full rate.
module gb_cpu_hram_responder
  import gb_cpu_common_pkg::*;
#(
  parameter logic [15:0] HRAM_BASE = 16'hFF80,
  parameter logic [15:0] IF_ADDR   = 16'hFF0F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [7:0]  wdata,
  input  irq_vec_t    irq_req,
  input  irq_vec_t    irq_ack,
  output logic        hit,
  output logic [7:0]  rdata,
  output logic        rdata_valid,
  output logic [7:0]  ie_out,
  output irq_vec_t    if_out,
  output logic        irq_pending
);

  tgt_e        tgt;
  logic [15:0] hram_off;
  logic        hram_sel;
  logic        rd_acc;
  logic        wr_acc;
  logic [7:0]  hram_rdata;
  logic [7:0]  rd_mux;

  logic [7:0]  ie_q, ie_d;
  irq_vec_t    if_q, if_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rvld_q, rvld_d;

  // Offset wraps for addresses below the base, so the range test also checks ordering
  assign hram_off = addr - HRAM_BASE;
  assign hram_sel = (addr >= HRAM_BASE) && (addr <= HRAM_LAST) &&
                    (hram_off[15:7] == 9'd0) && (hram_off[6:0] != 7'h7F);

  // Address decode; IE and IF win over HRAM so IE can never alias into storage
  always_comb begin
    tgt = TGT_NONE;
    if (addr == IE_ADDR) begin
      tgt = TGT_IE;
    end else if (addr == IF_ADDR) begin
      tgt = TGT_IF;
    end else if (hram_sel) begin
      tgt = TGT_HRAM;
    end
  end

  assign hit    = (tgt != TGT_NONE);
  assign rd_acc = rd_en && hit;
  assign wr_acc = wr_en && hit;

  // Writes are suppressed during reset so HRAM holds its pre-reset contents
  gb_cpu_hram u_hram (
    .clk     (clk),
    .we_i    (wr_acc && (tgt == TGT_HRAM) && !reset),
    .addr_i  (hram_off[6:0]),
    .wdata_i (wdata),
    .rdata_o (hram_rdata)
  );

  // Read source select; unimplemented IF bits read back as ones
  always_comb begin
    rd_mux = hram_rdata;
    case (tgt)
      TGT_IE:  rd_mux = ie_q;
      TGT_IF:  rd_mux = {3'b111, if_q};
      default: rd_mux = hram_rdata;
    endcase
  end

  // Next-state for IE/IF and the read stage; IF priority is set > ack > write > hold
  always_comb begin
    ie_d = ie_q;
    if (wr_acc && (tgt == TGT_IE)) begin
      ie_d = wdata;
    end
    if_d = if_q;
    if (wr_acc && (tgt == TGT_IF)) begin
      if_d = wdata[4:0];
    end
    if_d = irq_req | (~irq_ack & if_d);
    rdata_d = rd_acc ? rd_mux : rdata_q;
    rvld_d  = rd_acc;
  end

  // Register update; reset overrides every strobe and interrupt request
  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q    <= 8'h00;
      if_q    <= '0;
      rdata_q <= 8'hFF;
      rvld_q  <= 1'b0;
    end else begin
      ie_q    <= ie_d;
      if_q    <= if_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rvld_q;
  assign ie_out      = ie_q;
  assign if_out      = if_q;
  assign irq_pending = |(ie_q[4:0] & if_q);

endmodule

// File: tb/tb_gb_cpu_hram_responder.sv
// Randomized + directed bench for gb_cpu_hram_responder with a scoreboard of read responses.
// Latency: expects read data one cycle after each accepted read.
// Backpressure: none exercised; the DUT accepts every cycle.
module tb_gb_cpu_hram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic        rd_en;
  logic        wr_en;
  logic [7:0]  wdata;
  logic [4:0]  irq_req;
  logic [4:0]  irq_ack;
  logic        hit;
  logic [7:0]  rdata;
  logic        rdata_valid;
  logic [7:0]  ie_out;
  logic [4:0]  if_out;
  logic        irq_pending;

  gb_cpu_hram_responder dut (
    .clk         (clk),
    .reset       (reset),
    .addr        (addr),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .wdata       (wdata),
    .irq_req     (irq_req),
    .irq_ack     (irq_ack),
    .hit         (hit),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .ie_out      (ie_out),
    .if_out      (if_out),
    .irq_pending (irq_pending)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Expected outputs after the next rising edge
  typedef struct {
    logic       vld;
    logic [7:0] data;
    bit         dc;
  } exp_t;
  exp_t sb[$];

  // Reference state: a plain address-keyed memory view plus IE/IF
  logic [7:0] mem_m [int];
  logic [7:0] ie_m = 8'h00;
  logic [4:0] if_m = 5'h00;
  logic [7:0] rdata_m = 8'hFF;
  bit         rdata_dc = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic bit is_hram(logic [15:0] a);
    return (a >= 16'hFF80) && (a <= 16'hFFFE);
  endfunction

  function automatic bit m_hit(logic [15:0] a);
    return is_hram(a) || (a == 16'hFFFF) || (a == 16'hFF0F);
  endfunction

  // One bus cycle: check state, drive, check decode, predict, advance model
  task automatic cyc(input bit rst, input logic [15:0] a, input bit rd, input bit wr,
                     input logic [7:0] wd, input logic [4:0] req, input logic [4:0] ack);
    exp_t e;
    @(negedge clk);
    chk("ie_out", ie_out, ie_m);
    chk("if_out", if_out, if_m);
    chk("irq_pending", irq_pending, |(ie_m[4:0] & if_m));
    reset = rst; addr = a; rd_en = rd; wr_en = wr; wdata = wd; irq_req = req; irq_ack = ack;
    #1;
    chk("hit", hit, m_hit(a));
    e.vld = 1'b0; e.data = rdata_m; e.dc = rdata_dc;
    if (rst) begin
      ie_m = 8'h00; if_m = 5'h00; rdata_m = 8'hFF; rdata_dc = 1'b0;
      e.data = 8'hFF; e.dc = 1'b0;
    end else begin
      if (rd && m_hit(a)) begin
        e.vld = 1'b1;
        if (a == 16'hFFFF) begin e.data = ie_m; e.dc = 1'b0; end
        else if (a == 16'hFF0F) begin e.data = {3'b111, if_m}; e.dc = 1'b0; end
        else if (mem_m.exists(int'(a))) begin e.data = mem_m[int'(a)]; e.dc = 1'b0; end
        else begin e.data = 8'hxx; e.dc = 1'b1; end
        rdata_m = e.data; rdata_dc = e.dc;
      end
      for (int i = 0; i < 5; i++) begin
        if (req[i]) if_m[i] = 1'b1;
        else if (ack[i]) if_m[i] = 1'b0;
        else if (wr && a == 16'hFF0F) if_m[i] = wd[i];
      end
      if (wr && a == 16'hFFFF) ie_m = wd;
      if (wr && is_hram(a)) mem_m[int'(a)] = wd;
    end
    sb.push_back(e);
  endtask

  // Monitor: one expected entry per cycle, compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rdata_valid", rdata_valid, e.vld);
        if (!e.dc) chk("rdata", rdata, e.data);
      end
    end
  end

  initial begin
    logic [15:0] a;
    reset = 1'b1; addr = 16'h0000; rd_en = 1'b0; wr_en = 1'b0; wdata = 8'h00;
    irq_req = 5'h00; irq_ack = 5'h00;
    @(posedge clk);
    cyc(1, 16'h0000, 0, 0, 8'h00, 5'h00, 5'h00);

    // Write then read back HRAM base
    cyc(0, 16'hFF80, 0, 1, 8'hA5, 5'h00, 5'h00);
    cyc(0, 16'hFF80, 1, 0, 8'h00, 5'h00, 5'h00);
    cyc(0, 16'h1234, 0, 0, 8'h00, 5'h00, 5'h00);
    // IF write/read with upper bits forced to one
    cyc(0, 16'hFF0F, 0, 1, 8'hFF, 5'h00, 5'h00);
    cyc(0, 16'hFF0F, 1, 0, 8'h00, 5'h00, 5'h00);
    cyc(0, 16'hFF0F, 0, 1, 8'h00, 5'h00, 5'h00);
    cyc(0, 16'hFF0F, 1, 0, 8'h00, 5'h00, 5'h00);
    // Set beats ack beats write on the same bit
    cyc(0, 16'hFF0F, 0, 1, 8'h00, 5'b00100, 5'b00100);
    cyc(0, 16'hFFFF, 0, 1, 8'h04, 5'h00, 5'h00);
    cyc(0, 16'h0000, 0, 0, 8'h00, 5'h00, 5'h00);
    // Read-before-write at the last HRAM byte
    cyc(0, 16'hFFFE, 0, 1, 8'h11, 5'h00, 5'h00);
    cyc(0, 16'hFFFE, 1, 1, 8'h22, 5'h00, 5'h00);
    cyc(0, 16'hFFFE, 1, 0, 8'h00, 5'h00, 5'h00);
    // Out-of-range accesses, then IE write must not alias HRAM[126]
    cyc(0, 16'hFF7F, 1, 0, 8'h00, 5'h00, 5'h00);
    cyc(0, 16'hFF50, 0, 1, 8'h99, 5'h00, 5'h00);
    cyc(0, 16'hFFFF, 0, 1, 8'h1F, 5'h00, 5'h00);
    cyc(0, 16'hFFFE, 1, 0, 8'h00, 5'h00, 5'h00);
    // Reset with every strobe active; HRAM survives
    cyc(0, 16'hFF0F, 0, 1, 8'h1F, 5'h00, 5'h00);
    cyc(1, 16'hFF80, 1, 1, 8'h77, 5'h1F, 5'h00);
    cyc(0, 16'hFF80, 1, 0, 8'h00, 5'h00, 5'h00);
    cyc(0, 16'hFF80, 1, 0, 8'h00, 5'h00, 5'h00);

    // Randomized traffic, back-to-back
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 16'hFF80 + 16'($urandom_range(0, 126));
        4:          a = 16'hFFFF;
        5:          a = 16'hFF0F;
        6:          a = 16'hFF7F;
        7:          a = 16'hFF00 + 16'($urandom_range(0, 255));
        default:    a = 16'($urandom);
      endcase
      cyc(($urandom_range(0, 60) == 0), a, 1'($urandom), 1'($urandom), 8'($urandom),
          ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h00,
          ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h00);
    end

    cyc(0, 16'h0000, 0, 0, 8'h00, 5'h00, 5'h00);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gb_cpu_hram_responder.md
GB_CPU_HRAM_RESPONDER -- requirements
Module: gb_cpu_hram_responder

Interface
REQ-001 SHALL have parameter HRAM_BASE, default 16'hFF80, first HRAM address (HRAM spans HRAM_BASE..16'hFFFE, 127 bytes).
REQ-002 SHALL have parameter IF_ADDR, default 16'hFF0F, interrupt-flag register address.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 addr  input  16  CPU bus address (register file or IDU output).
REQ-006 rd_en  input  1  read strobe, sampled each cycle.
REQ-007 wr_en  input  1  write strobe, sampled each cycle.
REQ-008 wdata  input  8  write data.
REQ-009 irq_req  input  5  per-source interrupt set pulses (VBlank, STAT, Timer, Serial, Joypad = bits 0..4).
REQ-010 irq_ack  input  5  CPU dispatch clears for the IF bits.
REQ-011 hit  output  1  combinational: addr decodes to HRAM, IE (16'hFFFF) or IF_ADDR.
REQ-012 rdata  output  8  registered read data.
REQ-013 rdata_valid  output  1  high one cycle after an accepted read.
REQ-014 ie_out  output  8  current IE register.
REQ-015 if_out  output  5  current IF bits.
REQ-016 irq_pending  output  1  |(ie_out[4:0] & if_out), combinational.

Function
REQ-017 Read accepted when rd_en && hit; rdata and rdata_valid SHALL update on the next edge (latency 1).
REQ-018 rdata_valid SHALL be 0 in any cycle following a cycle with no accepted read; rdata SHALL hold its last value when no read is accepted.
REQ-019 IF read SHALL return {3'b111, IF}; IE read SHALL return all 8 bits; HRAM read SHALL return the stored byte.
REQ-020 Write accepted when wr_en && hit; target updated at the edge.
REQ-021 rd_en && wr_en to the same address SHALL perform read-before-write: rdata = old value, storage = wdata.
REQ-022 IF next-state per bit SHALL be: set if irq_req[i]; else cleared if irq_ack[i]; else wdata[i] if IF write accepted; else hold (set > ack > write).
REQ-023 Only wdata[4:0] SHALL be stored on an IF write; wdata[7:5] ignored.
REQ-024 Addresses outside HRAM/IE/IF SHALL give hit=0, cause no state change and no rdata_valid.
REQ-025 HRAM index SHALL be addr - HRAM_BASE (7 bits, 0..126); 16'hFFFF SHALL never alias into HRAM.
REQ-026 No internal state machine beyond the registered read stage; back-to-back reads every cycle SHALL be supported at full rate.

Reset
REQ-027 On reset: ie_out=8'h00, if_out=5'h00, rdata=8'hFF, rdata_valid=0; takes precedence over all strobes and irq_req in the same cycle.
REQ-028 HRAM contents SHALL NOT be reset (undefined after power-up, retained across reset).
REQ-029 A read accepted in the cycle reset is asserted SHALL be discarded (rdata_valid=0 next cycle).

Structure
REQ-030 Interrupt bit indices (IRQ_VBLANK..IRQ_JOYPAD), IE address 16'hFFFF and the 5-bit irq vector type SHALL live in gb_cpu_common_pkg.
REQ-031 HRAM storage SHALL be a sub-module gb_cpu_hram (127x8, synchronous write, combinational read) instantiated once; decode and IE/IF logic stay in the top.

Verification
REQ-032 Write 8'hA5 to 16'hFF80, read 16'hFF80 next cycle -> rdata=8'hA5, rdata_valid=1 exactly one cycle after rd_en.
REQ-033 Write IF=8'hFF -> if_out=5'h1F; read IF -> rdata=8'hFF; write IF=8'h00 -> read returns 8'hE0.
REQ-034 Same cycle: irq_req=5'b00100, irq_ack=5'b00100, IF write 8'h00 -> if_out[2]=1; IE=8'h04 -> irq_pending=1.
REQ-035 rd_en&&wr_en at 16'hFFFE, old 8'h11, wdata 8'h22 -> rdata=8'h11; subsequent read -> 8'h22.
REQ-036 Read 16'hFF7F and write 16'hFF50 -> hit=0, rdata_valid=0, IE/IF/HRAM unchanged; write 16'hFFFF=8'h1F -> ie_out=8'h1F, HRAM[126] unchanged.
REQ-037 Assert reset with rd_en, wr_en and irq_req=5'h1F active -> next cycle ie_out=0, if_out=0, rdata=8'hFF, rdata_valid=0; HRAM byte written before reset still reads back.
